// File: rtl/counter_timer_pkg.sv
// Shared constants for the multi-channel programmable counter/timer:
// mode encodings and control-register field layout.
package counter_timer_pkg;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RATE    = 2'd1;
    localparam logic [1:0] MODE_SQUARE  = 2'd2;
    localparam logic [1:0] MODE_FREE    = 2'd3;

    localparam int unsigned CTRL_MODE_LSB = 0;
    localparam int unsigned CTRL_EN       = 2;
    localparam int unsigned CTRL_STRIDE   = 4;

endpackage

// File: rtl/counter_timer_ch.sv
// One timer channel: down-counter, output flag and pending-load flag, advanced only on
// enabled tick strobes.
module counter_timer_ch
    import counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lock,
    input  logic             pend_set,
    input  logic             mode_chg,
    output logic [WIDTH-1:0] count,
    output logic             out
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             out_q, out_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] half;

    assign half = lock >> 1;

    always_comb begin
        count_d = count_q;
        out_d   = out_q;
        pend_d  = pend_q;
        if (tick && en) begin
            if (pend_q) begin
                pend_d  = 1'b0;
                count_d = (mode == MODE_SQUARE) ? half : lock;
                if (mode == MODE_ONESHOT) out_d = 1'b0;
                // Free-run output always mirrors the MSB of the count it now holds.
                if (mode == MODE_FREE) out_d = count_d[WIDTH-1];
            end else begin
                unique case (mode)
                    MODE_ONESHOT: begin
                        if (count_q != '0) count_d = count_q - WIDTH'(1);
                        if (count_d == '0) out_d = 1'b1;
                    end
                    MODE_RATE: begin
                        if (count_q == '0) begin
                            count_d = lock;
                            out_d   = 1'b1;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                            out_d   = 1'b0;
                        end
                    end
                    MODE_SQUARE: begin
                        if (count_q == '0) begin
                            count_d = half;
                            out_d   = ~out_q;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                    MODE_FREE: begin
                        count_d = count_q - WIDTH'(1);
                        out_d   = count_d[WIDTH-1];
                    end
                endcase
            end
        end
        // Register writes land after the tick has acted on the old state.
        if (pend_set) pend_d = 1'b1;
        if (mode_chg) begin
            out_d  = 1'b0;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            out_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
        end
    end

    assign count = count_q;
    assign out   = out_q;

endmodule

// File: rtl/counter_timer_n.sv
// N-channel programmable down-counter/timer: load registers, control register, write
// decode and combinational read-back around one counter_timer_ch per channel.
module counter_timer_n
    import counter_timer_pkg::*;
#(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(N_CH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  tick,
    input  logic             counter_we,
    input  logic [AW-1:0]    counter_ch,
    input  logic [WIDTH-1:0] counter_val,
    output logic [WIDTH-1:0] counter_out,
    output logic [N_CH-1:0]  counter_OUT
);

    localparam int unsigned CW = CTRL_STRIDE * N_CH;

    logic [CW-1:0]                ctrl_q;
    logic [CW-1:0]                ctrl_wdata;
    logic                         ctrl_we;
    logic [N_CH-1:0][WIDTH-1:0]   count_all;

    assign ctrl_we = counter_we && (counter_ch == AW'(N_CH));

    // Reserved bit of each channel nibble is never stored, so it reads back as 0.
    always_comb begin
        ctrl_wdata = counter_val[CW-1:0];
        for (int i = 0; i < N_CH; i++) begin
            ctrl_wdata[i*CTRL_STRIDE + CTRL_STRIDE - 1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (ctrl_we) begin
            ctrl_q <= ctrl_wdata;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] lock_q;
        logic             ch_we;
        logic [1:0]       mode;
        logic             mode_chg;

        assign ch_we    = counter_we && (counter_ch == AW'(i));
        assign mode     = ctrl_q[i*CTRL_STRIDE + CTRL_MODE_LSB +: 2];
        assign mode_chg = ctrl_we && (ctrl_wdata[i*CTRL_STRIDE + CTRL_MODE_LSB +: 2] != mode);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lock_q <= '0;
            end else if (ch_we) begin
                lock_q <= counter_val;
            end
        end

        counter_timer_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick[i]),
            .en      (ctrl_q[i*CTRL_STRIDE + CTRL_EN]),
            .mode    (mode),
            .lock    (lock_q),
            .pend_set(ch_we),
            .mode_chg(mode_chg),
            .count   (count_all[i]),
            .out     (counter_OUT[i])
        );
    end

    always_comb begin
        counter_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (counter_ch == AW'(i)) counter_out = count_all[i];
        end
        if (counter_ch == AW'(N_CH)) counter_out = WIDTH'(ctrl_q);
    end

endmodule

// File: tb/tb_counter_timer_n.sv
// Scoreboard bench for counter_timer_n: a 3x32 and a 4x8 instance driven with directed
// and random traffic, compared against a behavioural model of the timer rules.
module tb_counter_timer_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  tick_a;
    logic        we_a;
    logic [1:0]  ch_a;
    logic [31:0] val_a;
    logic [31:0] rd_a;
    logic [2:0]  out_a;
    logic [3:0]  tick_b;
    logic        we_b;
    logic [2:0]  ch_b;
    logic [7:0]  val_b;
    logic [7:0]  rd_b;
    logic [3:0]  out_b;

    counter_timer_n #(.N_CH(3), .WIDTH(32)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick_a),
        .counter_we (we_a),
        .counter_ch (ch_a),
        .counter_val(val_a),
        .counter_out(rd_a),
        .counter_OUT(out_a)
    );

    counter_timer_n #(.N_CH(4), .WIDTH(8)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick_b),
        .counter_we (we_b),
        .counter_ch (ch_b),
        .counter_val(val_b),
        .counter_out(rd_b),
        .counter_OUT(out_b)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0]  qa_out[$];
    logic [31:0] qa_rd[$];
    logic [3:0]  qb_out[$];
    logic [31:0] qb_rd[$];

    // Reference model state, index [dut][channel]
    logic [31:0] m_count[2][4];
    logic [31:0] m_lock[2][4];
    logic        m_out[2][4];
    logic        m_pend[2][4];
    logic [31:0] m_ctrl[2];

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int nch_of(int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic logic [31:0] mask_of(int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ctrl[d] = '0;
            for (int c = 0; c < 4; c++) begin
                m_count[d][c] = '0;
                m_lock[d][c]  = '0;
                m_out[d][c]   = 1'b0;
                m_pend[d][c]  = 1'b0;
            end
        end
    endtask

    task automatic model_step(int d, logic [3:0] t, bit we, int ch, logic [31:0] val);
        int          n;
        int          msb;
        logic [31:0] mk;
        logic [31:0] v;
        n   = nch_of(d);
        mk  = mask_of(d);
        msb = (d == 0) ? 31 : 7;
        v   = val & mk;
        for (int c = 0; c < n; c++) begin
            logic [1:0]  mode;
            logic        en;
            logic [31:0] cnt;
            logic        o;
            logic        p;
            mode = m_ctrl[d][4*c +: 2];
            en   = m_ctrl[d][4*c + 2];
            cnt  = m_count[d][c];
            o    = m_out[d][c];
            p    = m_pend[d][c];
            if (t[c] && en) begin
                if (p) begin
                    p   = 1'b0;
                    cnt = (mode == 2) ? m_lock[d][c] / 2 : m_lock[d][c];
                    if (mode == 0) o = 1'b0;
                    if (mode == 3) o = cnt[msb];
                end else if (mode == 0) begin
                    if (cnt != 0) cnt = cnt - 1;
                    if (cnt == 0) o = 1'b1;
                end else if (mode == 1) begin
                    o   = (cnt == 0);
                    cnt = (cnt == 0) ? m_lock[d][c] : cnt - 1;
                end else if (mode == 2) begin
                    if (cnt == 0) begin
                        o   = ~o;
                        cnt = m_lock[d][c] / 2;
                    end else begin
                        cnt = cnt - 1;
                    end
                end else begin
                    cnt = (cnt - 1) & mk;
                    o   = cnt[msb];
                end
            end
            if (we && ch == c) p = 1'b1;
            if (we && ch == n && v[4*c +: 2] != mode) begin
                o = 1'b0;
                p = 1'b1;
            end
            m_count[d][c] = cnt;
            m_out[d][c]   = o;
            m_pend[d][c]  = p;
        end
        if (we && ch < n) m_lock[d][ch] = v;
        if (we && ch == n) m_ctrl[d] = v & ((d == 0) ? 32'h0000_0777 : 32'h0000_7777);
    endtask

    function automatic logic [31:0] model_rd(int d, int ch);
        if (ch < nch_of(d)) return m_count[d][ch];
        if (ch == nch_of(d)) return m_ctrl[d];
        return 32'h0;
    endfunction

    // One clock of traffic on one instance; the other idles. Expected outputs after the
    // edge go into that instance's queue.
    task automatic cycle(int d, logic [3:0] t, bit we, int ch, logic [31:0] val);
        logic [3:0] eo;
        @(negedge clk);
        if (d == 0) begin
            tick_a = t[2:0];
            we_a   = we;
            ch_a   = 2'(ch);
            val_a  = val;
            model_step(0, {1'b0, t[2:0]}, we, ch, val);
        end else begin
            tick_b = t;
            we_b   = we;
            ch_b   = 3'(ch);
            val_b  = val[7:0];
            model_step(1, t, we, ch, val);
        end
        eo = '0;
        for (int c = 0; c < nch_of(d); c++) eo[c] = m_out[d][c];
        if (d == 0) begin
            qa_out.push_back(eo);
            qa_rd.push_back(model_rd(0, ch));
        end else begin
            qb_out.push_back(eo);
            qb_rd.push_back(model_rd(1, ch));
        end
        @(posedge clk);
        #2;
        tick_a = '0;
        we_a   = 1'b0;
        tick_b = '0;
        we_b   = 1'b0;
    endtask

    task automatic peek(int d, int ch, string nm, logic [31:0] er, logic [3:0] eo);
        if (d == 0) ch_a = 2'(ch);
        else        ch_b = 3'(ch);
        #1;
        if (d == 0) begin
            check({nm, "_rd"}, rd_a, er);
            check({nm, "_out"}, 32'(out_a), 32'(eo));
        end else begin
            check({nm, "_rd"}, 32'(rd_b), er);
            check({nm, "_out"}, 32'(out_b), 32'(eo));
        end
    endtask

    // Monitor: compares every DUT output that has an expectation queued.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa_out.size() > 0) begin
                check("sb_a_out", 32'(out_a), 32'(qa_out.pop_front()));
                check("sb_a_rd", rd_a, qa_rd.pop_front());
            end
            if (qb_out.size() > 0) begin
                check("sb_b_out", 32'(out_b), 32'(qb_out.pop_front()));
                check("sb_b_rd", 32'(rd_b), qb_rd.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick_a = '0; we_a = 1'b0; ch_a = '0; val_a = '0;
        tick_b = '0; we_b = 1'b0; ch_b = '0; val_b = '0;
        model_reset();
        #12;
        for (int c = 0; c < 4; c++) peek(0, c, "reset_a", 32'h0, 4'h0);
        for (int c = 0; c < 8; c++) peek(1, c, "reset_b", 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Disabled channels lose their ticks
        for (int i = 0; i < 4; i++) cycle(0, 4'h7, 1'b0, i, 0);

        // Mode 0 one-shot on ch0
        cycle(0, 4'h0, 1'b1, 0, 5);
        cycle(0, 4'h0, 1'b1, 3, 32'h4);
        for (int i = 0; i < 6; i++) cycle(0, 4'h1, 1'b0, 0, 0);
        peek(0, 0, "m0_zero", 0, 4'b0001);
        for (int i = 0; i < 10; i++) cycle(0, 4'h1, 1'b0, 0, 0);
        peek(0, 0, "m0_hold", 0, 4'b0001);
        cycle(0, 4'h0, 1'b1, 0, 2);
        cycle(0, 4'h1, 1'b0, 0, 0);
        peek(0, 0, "m0_reload", 2, 4'b0000);

        // Mode 1 rate generator on ch1
        cycle(0, 4'h0, 1'b1, 1, 3);
        cycle(0, 4'h0, 1'b1, 3, 32'h54);
        for (int i = 0; i < 13; i++) cycle(0, 4'h2, 1'b0, 1, 0);
        peek(0, 1, "m1_period", 3, 4'b0010);
        cycle(0, 4'h0, 1'b1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'h2, 1'b0, 1, 0);
        peek(0, 1, "m1_lock0", 0, 4'b0010);

        // Mode 2 square wave on ch2
        cycle(0, 4'h0, 1'b1, 2, 8);
        cycle(0, 4'h0, 1'b1, 3, 32'h654);
        for (int i = 0; i < 21; i++) cycle(0, 4'h4, 1'b0, 2, 0);
        peek(0, 2, "m2_half", 4, 4'b0010);
        cycle(0, 4'h0, 1'b1, 2, 1);
        for (int i = 0; i < 4; i++) cycle(0, 4'h4, 1'b0, 2, 0);
        peek(0, 2, "m2_fast", 0, 4'b0110);

        // Write and tick in the same cycle on ch0 in mode 1 with count 0
        cycle(0, 4'h0, 1'b1, 3, 32'h655);
        cycle(0, 4'h0, 1'b1, 0, 0);
        cycle(0, 4'h1, 1'b0, 0, 0);
        cycle(0, 4'h1, 1'b1, 0, 7);
        peek(0, 0, "same_cycle", 0, 4'b0111);
        cycle(0, 4'h1, 1'b0, 0, 0);
        peek(0, 0, "reload7", 7, 4'b0111);

        // Random traffic on the 3x32 instance
        for (int i = 0; i < 300; i++) begin
            int          ch;
            bit          we;
            logic [31:0] v;
            ch = $urandom_range(0, 3);
            we = ($urandom_range(0, 3) == 0);
            if (ch == 3) v = $urandom | 32'h444;
            else v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            cycle(0, 4'($urandom_range(0, 15)), we, ch, v);
        end

        // Reset in the middle of counting
        cycle(0, 4'h7, 1'b0, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_out_a", 32'(out_a), 32'h0);
        check("rst_mid_rd_a", rd_a, 32'h0);
        check("rst_mid_out_b", 32'(out_b), 32'h0);
        model_reset();
        tick_a = 3'h7; we_a = 1'b1; ch_a = 2'd3; val_a = 32'h777;
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b0;
        tick_a = '0; we_a = 1'b0;
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 1'b0, i, 0);

        // Mode 3 free-run on the 4x8 instance
        cycle(1, 4'h0, 1'b1, 0, 1);
        cycle(1, 4'h0, 1'b1, 4, 32'h7);
        for (int i = 0; i < 3; i++) cycle(1, 4'h1, 1'b0, 0, 0);
        peek(1, 0, "m3_wrap", 32'hFF, 4'b0001);
        peek(1, 4, "ctrl_rd", 32'h7, 4'b0001);
        for (int c = 5; c < 8; c++) peek(1, c, "hi_addr", 32'h0, 4'b0001);

        // Random traffic on the 4x8 instance, including unmapped selects
        for (int i = 0; i < 300; i++) begin
            int          ch;
            bit          we;
            logic [31:0] v;
            ch = $urandom_range(0, 7);
            we = ($urandom_range(0, 3) == 0);
            if (ch == 4) v = $urandom | 32'h4444;
            else v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            cycle(1, 4'($urandom_range(0, 15)), we, ch, v);
        end

        @(posedge clk);
        #3;
        check("queues_drained", 32'(qa_out.size() + qb_out.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
